// File: rtl/fir_stream_pkg.sv
// Shared types and sizing helpers for the FIR stream source.
package fir_stream_pkg;

  localparam int unsigned DATA_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    STOP
  } state_t;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fir_src_fifo.sv
// Sample FIFO for the FIR stream source: storage, pointers, occupancy,
// push acceptance and the sticky overflow flag.
module fir_src_fifo
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_req,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           rd_data,
  output logic [level_w(DEPTH)-1:0]   level,
  output logic                        full,
  output logic                        accept,
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = level_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign full    = (level == LVL_W'(DEPTH));
  // A pop in the same cycle frees the slot the push lands in.
  assign accept  = push_req && (!full || pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop)      level <= level + LVL_W'(1);
      else if (!accept && pop) level <= level - LVL_W'(1);
      if (push_req && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/fir_stream_source.sv
// Stream transmitter feeding signed samples to the FIR sample port.
// Optional internal ramp source enabled by defining FIR_SRC_RAMP_EN.
module fir_stream_source
  import fir_stream_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned START_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_strobe,
  input  logic                      run,
  input  logic                      pattern_sel,
  output logic                      in_full,
  output logic [level_w(DEPTH)-1:0] level,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      overflow,
  output logic                      underrun
);

  localparam int unsigned LVL_W = level_w(DEPTH);

  state_t             state;
  logic               handshake;
  logic               push_req;
  logic [DATA_W-1:0]  push_data;
  logic               accept;

  assign handshake = m_axis_tvalid && m_axis_tready;

`ifdef FIR_SRC_RAMP_EN
  logic [DATA_W-1:0] ramp_q;

  // Ramp only requests when a slot is free, so it can never overflow.
  assign push_req  = pattern_sel ? (!in_full || handshake) : in_strobe;
  assign push_data = pattern_sel ? ramp_q : in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    ramp_q <= '0;
    else if (pattern_sel && accept) ramp_q <= ramp_q + DATA_W'(1);
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign push_req  = in_strobe;
  assign push_data = in_data;
`endif

  fir_src_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_req  (push_req),
    .push_data (push_data),
    .pop       (handshake),
    .rd_data   (m_axis_tdata),
    .level     (level),
    .full      (in_full),
    .accept    (accept),
    .overflow  (overflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      m_axis_tvalid <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run && level >= LVL_W'(START_LEVEL)) begin
            state         <= STREAM;
            m_axis_tvalid <= 1'b1;
          end
        end
        STREAM: begin
          // A stop that coincides with a handshake has nothing left to hold.
          if (!run) begin
            if (handshake) begin
              state         <= IDLE;
              m_axis_tvalid <= 1'b0;
            end else begin
              state <= STOP;
            end
          end else if (handshake && level == LVL_W'(1) && !accept) begin
            underrun      <= 1'b1;
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
          end
        end
        STOP: begin
          if (handshake) begin
            state         <= IDLE;
            m_axis_tvalid <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_source.sv
// Self-checking bench for fir_stream_source (ramp checks under FIR_SRC_RAMP_EN).
module tb_fir_stream_source;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in_data;
  logic       in_strobe;
  logic       run;
  logic       pattern_sel;
  logic       in_full;
  logic [2:0] level;
  logic [5:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       overflow;
  logic       underrun;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [5:0]  sb_q[$];

  typedef struct {
    logic       str;
    logic [5:0] d;
    logic       run;
    logic       rdy;
    logic       e_valid;
    logic [2:0] e_level;
    logic       e_full;
    logic       e_ovf;
    logic       e_und;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  fir_stream_source #(
    .DATA_W      (6),
    .DEPTH       (4),
    .START_LEVEL (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_strobe     (in_strobe),
    .run           (run),
    .pattern_sel   (pattern_sel),
    .in_full       (in_full),
    .level         (level),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow),
    .underrun      (underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes are scored at the negedge, mid-cycle, then the clock advances.
  task automatic tick();
    @(negedge clk);
    if (reset && m_axis_tvalid && m_axis_tready) begin
      if (sb_q.size() == 0) chk("hs_unexpected", 32'(m_axis_tdata), 32'hDEAD);
      else chk("hs_data", 32'(m_axis_tdata), 32'(sb_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] d, input logic expect_accept);
    in_strobe = 1'b1;
    in_data   = d;
    if (expect_accept) sb_q.push_back(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    #3 reset = 1'b1;
    in_strobe = 1'b0;
    run = 1'b0;
    m_axis_tready = 1'b0;
    pattern_sel = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic v, input logic [2:0] l,
                            input logic f, input logic o, input logic u);
    chk({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'(v));
    chk({tag, "_level"}, 32'(level), 32'(l));
    chk({tag, "_full"}, 32'(in_full), 32'(f));
    chk({tag, "_ovf"}, 32'(overflow), 32'(o));
    chk({tag, "_und"}, 32'(underrun), 32'(u));
  endtask

  initial begin
    reset = 1'b0; in_data = '0; in_strobe = 1'b0; run = 1'b0;
    pattern_sel = 1'b0; m_axis_tready = 1'b0;

    vecs[0] = '{1'b1, 6'h03, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 6'h3E, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 6'h07, 1'b1, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 6'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};

    #1;
    chk_status("rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'h0);
    tick();
    reset = 1'b1;
    tick();

    // Push 3,-2,7 and stream until underrun.
    for (int i = 0; i < 7; i++) begin
      in_strobe = vecs[i].str;
      in_data   = vecs[i].d;
      run       = vecs[i].run;
      m_axis_tready = vecs[i].rdy;
      if (vecs[i].str) sb_q.push_back(vecs[i].d);
      tick();
      chk_status($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_level,
                 vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_und);
    end
    in_strobe = 1'b0;
    chk("vec_sb_empty", 32'(sb_q.size()), 32'd0);

    do_reset();
    tick();

    // Fill to DEPTH with the sink stalled.
    run = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(6'(i), 1'b1);
      tick();
    end
    in_strobe = 1'b0;
    chk_status("fill", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("fill_tdata", 32'(m_axis_tdata), 32'h1);

    // Full FIFO, push and handshake together.
    push(6'h05, 1'b1);
    m_axis_tready = 1'b1;
    tick();
    in_strobe = 1'b0;
    m_axis_tready = 1'b0;
    chk_status("full_pp", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("full_pp_tdata", 32'(m_axis_tdata), 32'h2);

    // Push into full FIFO with no pop is dropped.
    push(6'h06, 1'b0);
    tick();
    in_strobe = 1'b0;
    chk_status("ovf", 1'b1, 3'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("stall%0d_tdata", i), 32'(m_axis_tdata), 32'h2);
      chk($sformatf("stall%0d_tvalid", i), 32'(m_axis_tvalid), 32'h1);
    end

    // Stop with sink stalled: tvalid held until one handshake.
    run = 1'b0;
    tick();
    tick();
    chk("stop_hold_tvalid", 32'(m_axis_tvalid), 32'h1);
    chk("stop_hold_tdata", 32'(m_axis_tdata), 32'h2);
    m_axis_tready = 1'b1;
    tick();
    chk_status("stop_hs", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk_status("stop_idle", 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    chk("stop_tdata", 32'(m_axis_tdata), 32'h3);
    chk("stop_sb_left", 32'(sb_q.size()), 32'd3);

    // Restart, then reset asynchronously while streaming.
    m_axis_tready = 1'b0;
    run = 1'b1;
    tick();
    chk("pre_rst_tvalid", 32'(m_axis_tvalid), 32'h1);
    #2 reset = 1'b0;
    sb_q.delete();
    #1;
    chk_status("mid_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_tdata", 32'(m_axis_tdata), 32'h0);
    #1 reset = 1'b1;
    run = 1'b0;
    tick();
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'h0);

`ifdef FIR_SRC_RAMP_EN
    begin
      logic [5:0] rv;
      int unsigned waited;
      do_reset();
      rv = '0;
      for (int i = 0; i < 34; i++) begin
        sb_q.push_back(rv);
        rv = rv + 6'd1;
      end
      pattern_sel = 1'b1;
      run = 1'b1;
      m_axis_tready = 1'b1;
      waited = 0;
      while (!m_axis_tvalid && waited < 10) begin
        tick();
        waited++;
      end
      chk("ramp_start_cycles", 32'(waited), 32'd3);
      for (int i = 0; i < 34; i++) begin
        tick();
        chk($sformatf("ramp_nogap%0d", i), 32'(m_axis_tvalid), 32'h1);
      end
      chk("ramp_sb_empty", 32'(sb_q.size()), 32'd0);
      chk("ramp_ovf", 32'(overflow), 32'h0);
      m_axis_tready = 1'b0;
      pattern_sel = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
